// File: rtl/ad936x_sdr_framer.sv
// AD936x-style SDR data-port framer: TX FIFO + word serializer onto p1_d/tx_frame,
// RX frame-aligned word assembler from p0_d/rx_frame with a one-deep output register.
//   state  | meaning
//   S_IDLE | serializer parked, p1_d and tx_frame held at 0
//   S_RUN  | driving word k of the current group, one word per cycle
module ad936x_sdr_framer #(
    parameter int DW    = 12,
    parameter int NCH   = 1,
    parameter int DEPTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tx_en,
    input  logic                tx_valid,
    input  logic [2*NCH*DW-1:0] tx_data,
    output logic                tx_ready,
    output logic                tx_frame,
    output logic [DW-1:0]       p1_d,
    input  logic                rx_frame,
    input  logic [DW-1:0]       p0_d,
    output logic                rx_valid,
    output logic [2*NCH*DW-1:0] rx_data,
    input  logic                rx_ready,
    output logic                rx_locked,
    output logic [15:0]         tx_underflow_cnt,
    output logic [15:0]         rx_overflow_cnt,
    output logic [15:0]         rx_frame_err_cnt
);

    localparam int GW = 2 * NCH * DW;
    localparam int NW = 2 * NCH;
    localparam int AW = $clog2(DEPTH);
    localparam int KW = $clog2(NW);
    localparam logic [KW-1:0] K_LAST = KW'(NW - 1);

    typedef enum logic {S_IDLE, S_RUN} tx_state_t;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // TX FIFO storage and pointers (extra MSB distinguishes full from empty)
    logic [GW-1:0] mem_q [DEPTH];
    logic [AW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic          ready_q, ready_d;
    logic          fifo_empty, fifo_full, wr_en, pop;
    logic [GW-1:0] rd_data;

    tx_state_t     state_q, state_d;
    logic [KW-1:0] k_q, k_d, k_inc;
    logic [GW-1:0] cur_q, cur_d;
    logic [DW-1:0] p1_d_q, p1_d_d;
    logic          tx_frame_q, tx_frame_d;
    logic [15:0]   und_q, und_d;

    logic          rxf_q, rxf_d, rxf_prev_q, rxf_prev_d;
    logic [DW-1:0] rxd_q, rxd_d;
    logic          locked_q, locked_d;
    logic [KW-1:0] rx_k_q, rx_k_d;
    logic [GW-1:0] asm_q, asm_d;
    logic          rx_valid_q, rx_valid_d;
    logic [GW-1:0] rx_data_q, rx_data_d;
    logic [15:0]   ovf_q, ovf_d, ferr_q, ferr_d;
    logic          done;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign tx_ready   = ready_q && !fifo_full;
    assign wr_en      = tx_valid && tx_ready;
    assign rd_data    = mem_q[rd_ptr_q[AW-1:0]];
    assign k_inc      = k_q + KW'(1);

    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        cur_d      = cur_q;
        p1_d_d     = p1_d_q;
        tx_frame_d = tx_frame_q;
        und_d      = und_q;
        pop        = 1'b0;
        ready_d    = 1'b1;
        case (state_q)
            S_IDLE: begin
                p1_d_d     = '0;
                tx_frame_d = 1'b0;
                if (tx_en && !fifo_empty) begin
                    pop        = 1'b1;
                    state_d    = S_RUN;
                    cur_d      = rd_data;
                    k_d        = '0;
                    p1_d_d     = rd_data[DW-1:0];
                    tx_frame_d = 1'b1;
                end
            end
            S_RUN: begin
                if (k_q == K_LAST) begin
                    if (tx_en && !fifo_empty) begin
                        pop        = 1'b1;
                        cur_d      = rd_data;
                        k_d        = '0;
                        p1_d_d     = rd_data[DW-1:0];
                        tx_frame_d = 1'b1;
                    end else begin
                        state_d    = S_IDLE;
                        k_d        = '0;
                        p1_d_d     = '0;
                        tx_frame_d = 1'b0;
                        if (tx_en) und_d = sat_inc(und_q);
                    end
                end else begin
                    k_d        = k_inc;
                    p1_d_d     = cur_q[int'(k_inc)*DW +: DW];
                    tx_frame_d = (int'(k_inc) < NCH);
                end
            end
            default: state_d = S_IDLE;
        endcase
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, wr_en};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};
    end

    // RX: alignment acquired on a rising frame edge, dropped on any pattern mismatch
    always_comb begin
        rxf_d      = rx_frame;
        rxd_d      = p0_d;
        rxf_prev_d = rxf_q;
        asm_d      = asm_q;
        locked_d   = locked_q;
        rx_k_d     = rx_k_q;
        ferr_d     = ferr_q;
        ovf_d      = ovf_q;
        rx_valid_d = rx_valid_q;
        rx_data_d  = rx_data_q;
        done       = 1'b0;
        if (locked_q) begin
            if (rxf_q != (int'(rx_k_q) < NCH)) begin
                locked_d = 1'b0;
                rx_k_d   = '0;
                ferr_d   = sat_inc(ferr_q);
            end else begin
                asm_d[int'(rx_k_q)*DW +: DW] = rxd_q;
                if (rx_k_q == K_LAST) begin
                    done   = 1'b1;
                    rx_k_d = '0;
                end else begin
                    rx_k_d = rx_k_q + KW'(1);
                end
            end
        end else if (rxf_q && !rxf_prev_q) begin
            asm_d[DW-1:0] = rxd_q;
            locked_d      = 1'b1;
            rx_k_d        = KW'(1);
        end
        if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;
        if (done) begin
            if (!rx_valid_q || rx_ready) begin
                rx_valid_d = 1'b1;
                rx_data_d  = asm_d;
            end else begin
                ovf_d = sat_inc(ovf_q);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= tx_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            ready_q    <= 1'b0;
            state_q    <= S_IDLE;
            k_q        <= '0;
            cur_q      <= '0;
            p1_d_q     <= '0;
            tx_frame_q <= 1'b0;
            und_q      <= '0;
            rxf_q      <= 1'b0;
            rxd_q      <= '0;
            rxf_prev_q <= 1'b0;
            locked_q   <= 1'b0;
            rx_k_q     <= '0;
            asm_q      <= '0;
            rx_valid_q <= 1'b0;
            rx_data_q  <= '0;
            ovf_q      <= '0;
            ferr_q     <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            ready_q    <= ready_d;
            state_q    <= state_d;
            k_q        <= k_d;
            cur_q      <= cur_d;
            p1_d_q     <= p1_d_d;
            tx_frame_q <= tx_frame_d;
            und_q      <= und_d;
            rxf_q      <= rxf_d;
            rxd_q      <= rxd_d;
            rxf_prev_q <= rxf_prev_d;
            locked_q   <= locked_d;
            rx_k_q     <= rx_k_d;
            asm_q      <= asm_d;
            rx_valid_q <= rx_valid_d;
            rx_data_q  <= rx_data_d;
            ovf_q      <= ovf_d;
            ferr_q     <= ferr_d;
        end
    end

    assign p1_d             = p1_d_q;
    assign tx_frame         = tx_frame_q;
    assign rx_valid         = rx_valid_q;
    assign rx_data          = rx_data_q;
    assign rx_locked        = locked_q;
    assign tx_underflow_cnt = und_q;
    assign rx_overflow_cnt  = ovf_q;
    assign rx_frame_err_cnt = ferr_q;

endmodule

// File: tb/tb_ad936x_sdr_framer.sv
// Bench for ad936x_sdr_framer: a 1R1T instance for the single-group TX case and a
// 2R2T instance checked every cycle against a queue-based model plus literal checkpoints.
module tb_ad936x_sdr_framer;

    localparam int DW = 12;
    localparam int DEPTH = 8;

    logic clk, rst;

    logic        tx_en1, tx_valid1, tx_ready1, tx_frame1, rx_frame1, rx_valid1, rx_ready1, rx_locked1;
    logic [23:0] tx_data1, rx_data1;
    logic [11:0] p1_d1, p0_d1;
    logic [15:0] und1, ovf1, ferr1;

    logic        tx_en2, tx_valid2, tx_ready2, tx_frame2, rx_frame2, rx_valid2, rx_ready2, rx_locked2;
    logic [47:0] tx_data2, rx_data2;
    logic [11:0] p1_d2, p0_d2;
    logic [15:0] und2, ovf2, ferr2;

    int checks = 0;
    int failures = 0;

    ad936x_sdr_framer #(.DW(DW), .NCH(1), .DEPTH(DEPTH)) u_dut1 (
        .clk(clk), .rst(rst), .tx_en(tx_en1), .tx_valid(tx_valid1), .tx_data(tx_data1),
        .tx_ready(tx_ready1), .tx_frame(tx_frame1), .p1_d(p1_d1), .rx_frame(rx_frame1),
        .p0_d(p0_d1), .rx_valid(rx_valid1), .rx_data(rx_data1), .rx_ready(rx_ready1),
        .rx_locked(rx_locked1), .tx_underflow_cnt(und1), .rx_overflow_cnt(ovf1),
        .rx_frame_err_cnt(ferr1));

    ad936x_sdr_framer #(.DW(DW), .NCH(2), .DEPTH(DEPTH)) u_dut2 (
        .clk(clk), .rst(rst), .tx_en(tx_en2), .tx_valid(tx_valid2), .tx_data(tx_data2),
        .tx_ready(tx_ready2), .tx_frame(tx_frame2), .p1_d(p1_d2), .rx_frame(rx_frame2),
        .p0_d(p0_d2), .rx_valid(rx_valid2), .rx_data(rx_data2), .rx_ready(rx_ready2),
        .rx_locked(rx_locked2), .tx_underflow_cnt(und2), .rx_overflow_cnt(ovf2),
        .rx_frame_err_cnt(ferr2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [11:0] txw(input int g, input int k);
        return 12'(12'h800 + g * 16 + k);
    endfunction

    function automatic logic [47:0] txg(input int g);
        return {txw(g, 3), txw(g, 2), txw(g, 1), txw(g, 0)};
    endfunction

    // Model of the NCH=2 instance: FIFO as a queue, serializer as "group + word index"
    logic [47:0] mq[$];
    logic [47:0] m_grp, m_rdata;
    logic [11:0] m_w[4];
    logic [11:0] m_rd;
    int  m_idx = -1, m_und = 0, m_k = 0, m_ovf = 0, m_ferr = 0;
    bit  m_rdy = 0, m_rf = 0, m_rfp = 0, m_lk = 0, m_rv = 0, m_live = 0;
    bit  m_wr, m_canpop, m_done;

    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            m_idx = -1; m_rdy = 0; m_und = 0;
            m_rf = 0; m_rfp = 0; m_rd = '0; m_lk = 0; m_k = 0;
            m_rv = 0; m_rdata = '0; m_ovf = 0; m_ferr = 0;
        end else begin
            m_wr     = tx_valid2 && m_rdy && (mq.size() < DEPTH);
            m_canpop = tx_en2 && (mq.size() > 0);
            if (m_idx >= 0 && m_idx < 3) m_idx++;
            else if (m_canpop) begin
                m_grp = mq.pop_front();
                m_idx = 0;
            end else begin
                if (m_idx == 3 && tx_en2 && m_und < 65535) m_und++;
                m_idx = -1;
            end
            if (m_wr) mq.push_back(tx_data2);
            m_rdy = 1;

            m_done = 0;
            if (m_lk) begin
                if (m_rf != (m_k < 2)) begin
                    m_lk = 0; m_k = 0;
                    if (m_ferr < 65535) m_ferr++;
                end else begin
                    m_w[m_k] = m_rd;
                    if (m_k == 3) begin m_done = 1; m_k = 0; end
                    else m_k++;
                end
            end else if (m_rf && !m_rfp) begin
                m_w[0] = m_rd; m_lk = 1; m_k = 1;
            end
            if (m_done) begin
                if (!m_rv || rx_ready2) begin
                    m_rv = 1;
                    m_rdata = {m_w[3], m_w[2], m_w[1], m_w[0]};
                end else if (m_ovf < 65535) m_ovf++;
            end else if (m_rv && rx_ready2) m_rv = 0;
            m_rfp = m_rf; m_rf = rx_frame2; m_rd = p0_d2;
        end
        m_live = 1;
    end

    always @(negedge clk) begin
        if (m_live) begin
            chk("model_tx_ready", 64'(tx_ready2), 64'(m_rdy && (mq.size() < DEPTH)));
            chk("model_p1_d", 64'(p1_d2), (m_idx < 0) ? 64'd0 : 64'(m_grp[m_idx*12 +: 12]));
            chk("model_tx_frame", 64'(tx_frame2), 64'(m_idx >= 0 && m_idx < 2));
            chk("model_tx_underflow", 64'(und2), 64'(m_und));
            chk("model_rx_valid", 64'(rx_valid2), 64'(m_rv));
            if (m_rv) chk("model_rx_data", 64'(rx_data2), 64'(m_rdata));
            chk("model_rx_locked", 64'(rx_locked2), 64'(m_lk));
            chk("model_rx_overflow", 64'(ovf2), 64'(m_ovf));
            chk("model_rx_frame_err", 64'(ferr2), 64'(m_ferr));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    bit          sf[$];
    logic [11:0] sd[$];
    bit          frm_pat[4] = '{1'b1, 1'b1, 1'b0, 1'b0};

    task automatic put_group(input int g);
        for (int k = 0; k < 4; k++) begin
            sf.push_back(frm_pat[k]);
            sd.push_back(12'(12'h100 * (g + 1) + 12'h10 * k + 1));
        end
    endtask

    initial begin
        rst = 1; tx_en1 = 0; tx_valid1 = 0; tx_data1 = '0; rx_frame1 = 0; p0_d1 = '0; rx_ready1 = 1;
        tx_en2 = 0; tx_valid2 = 0; tx_data2 = '0; rx_frame2 = 0; p0_d2 = '0; rx_ready2 = 1;
        put_group(0); put_group(1);
        sf.push_back(1); sd.push_back(12'hEE0);
        sf.push_back(1); sd.push_back(12'hEE1);
        sf.push_back(1); sd.push_back(12'hEE2);
        for (int i = 0; i < 3; i++) begin sf.push_back(0); sd.push_back(12'h0F0); end
        put_group(2); put_group(3); put_group(4);

        repeat (3) @(negedge clk);
        chk("rst_tx_ready1", 64'(tx_ready1), 64'd0);
        chk("rst_tx_ready2", 64'(tx_ready2), 64'd0);
        chk("rst_p1_d", 64'(p1_d2), 64'd0);
        chk("rst_tx_frame", 64'(tx_frame2), 64'd0);
        chk("rst_rx_valid", 64'(rx_valid2), 64'd0);
        chk("rst_rx_data", 64'(rx_data2), 64'd0);
        chk("rst_rx_locked", 64'(rx_locked2), 64'd0);
        chk("rst_counters", 64'({und2, ovf2, ferr2}), 64'd0);
        rst = 0;
        @(negedge clk);
        chk("post_rst_tx_ready1", 64'(tx_ready1), 64'd1);
        chk("post_rst_tx_ready2", 64'(tx_ready2), 64'd1);

        // single 1R1T group: I at t+2 with frame high, Q at t+3, idle at t+4
        tx_en1 = 1; tx_valid1 = 1; tx_data1 = {12'h456, 12'h123};
        @(negedge clk); tx_valid1 = 0;
        chk("nch1_t1_p1_d", 64'(p1_d1), 64'd0);
        @(negedge clk);
        chk("nch1_t2_p1_d", 64'(p1_d1), 64'h123);
        chk("nch1_t2_frame", 64'(tx_frame1), 64'd1);
        @(negedge clk);
        chk("nch1_t3_p1_d", 64'(p1_d1), 64'h456);
        chk("nch1_t3_frame", 64'(tx_frame1), 64'd0);
        @(negedge clk);
        chk("nch1_t4_p1_d", 64'(p1_d1), 64'd0);
        chk("nch1_t4_frame", 64'(tx_frame1), 64'd0);
        chk("nch1_t4_underflow", 64'(und1), 64'd1);
        tx_en1 = 0;

        // three back-to-back 2R2T groups: 12 gapless words, frame 1100 x3
        tx_en2 = 1;
        for (int c = 0; c < 14; c++) begin
            if (c < 3) begin tx_valid2 = 1; tx_data2 = txg(c); end
            else tx_valid2 = 0;
            if (c >= 2) begin
                chk("b2b_p1_d", 64'(p1_d2), 64'(txw((c - 2) / 4, (c - 2) % 4)));
                chk("b2b_frame", 64'(tx_frame2), 64'(frm_pat[(c - 2) % 4]));
                chk("b2b_tx_ready", 64'(tx_ready2), 64'd1);
            end
            @(negedge clk);
        end
        chk("b2b_after_p1_d", 64'(p1_d2), 64'd0);
        chk("b2b_after_underflow", 64'(und2), 64'd1);
        tx_en2 = 0;

        // RX stream: lock, framing error, relock, backpressure drop
        for (int s = 0; s < 30; s++) begin
            rx_frame2 = (s < sf.size()) ? sf[s] : 1'b0;
            p0_d2     = (s < sd.size()) ? sd[s] : 12'h000;
            rx_ready2 = !(s >= 18 && s < 23);
            case (s)
                2: chk("rx_lock_acquired", 64'(rx_locked2), 64'd1);
                5: begin
                    chk("rx_g0_valid", 64'(rx_valid2), 64'd1);
                    chk("rx_g0_data", 64'(rx_data2), 64'h131121111101);
                end
                12: begin
                    chk("rx_ferr_cnt", 64'(ferr2), 64'd1);
                    chk("rx_ferr_unlocked", 64'(rx_locked2), 64'd0);
                end
                13: chk("rx_ferr_no_group", 64'(rx_valid2), 64'd0);
                16: chk("rx_relocked", 64'(rx_locked2), 64'd1);
                19, 21: chk("rx_g2_held", 64'(rx_data2), 64'h331321311301);
                23: begin
                    chk("rx_bp_valid", 64'(rx_valid2), 64'd1);
                    chk("rx_bp_data", 64'(rx_data2), 64'h331321311301);
                    chk("rx_bp_overflow", 64'(ovf2), 64'd1);
                end
                default: ;
            endcase
            @(negedge clk);
        end
        rx_ready2 = 1;

        // reset while serializing with three groups queued
        tx_en2 = 1;
        for (int c = 0; c < 4; c++) begin
            tx_valid2 = 1; tx_data2 = txg(10 + c);
            @(negedge clk);
        end
        tx_valid2 = 0;
        chk("midrst_running_p1_d", 64'(p1_d2), 64'(txw(10, 2)));
        rst = 1;
        @(negedge clk);
        chk("midrst_p1_d", 64'(p1_d2), 64'd0);
        chk("midrst_frame", 64'(tx_frame2), 64'd0);
        chk("midrst_tx_ready", 64'(tx_ready2), 64'd0);
        chk("midrst_counters", 64'({und2, ovf2, ferr2}), 64'd0);
        rst = 0;
        @(negedge clk);
        chk("midrst_release_ready", 64'(tx_ready2), 64'd1);
        repeat (3) begin
            @(negedge clk);
            chk("midrst_fifo_empty_p1_d", 64'(p1_d2), 64'd0);
            chk("midrst_fifo_empty_frame", 64'(tx_frame2), 64'd0);
        end

        // fill the FIFO with the serializer held off, then drain it
        tx_en2 = 0;
        for (int c = 0; c < 9; c++) begin
            if (c == 8) chk("full_tx_ready", 64'(tx_ready2), 64'd0);
            tx_valid2 = 1; tx_data2 = txg(20 + c);
            @(negedge clk);
        end
        tx_valid2 = 0; tx_en2 = 1;
        @(negedge clk);
        chk("drain_first_word", 64'(p1_d2), 64'(txw(20, 0)));
        repeat (40) @(negedge clk);
        chk("drain_done_p1_d", 64'(p1_d2), 64'd0);
        chk("drain_done_ready", 64'(tx_ready2), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
